// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline data-memory path:
//   - memState_t      : MEM-stage access controller state encoding
//   - WORD_ALIGN_MASK : low address bits that must be zero for a word access
//   - DEFAULT_*_WIDTH : default data / address widths
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 32;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } memState_t;

endpackage

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM-stage data-memory access controller. Converts memRead/memWrite from the
// EX/MEM register into a request/acknowledge transaction on a multi-cycle bus,
// stalls the pipeline while the transaction is outstanding, and buffers read
// data for the MEM/WB register.
//
// Ports:
//   clk, reset       : pipeline clock, asynchronous active-low reset
//   memReadIn        : load control from EX/MEM
//   memWriteIn       : store control from EX/MEM (wins when both are high)
//   addrIn           : effective byte address from EX/MEM
//   writeDataIn      : store data from EX/MEM
//   dataMemoryOut    : registered read buffer, feeds MEM/WB
//   stallOut         : freeze the pipeline while high (combinational)
//   busErrorOut      : one-cycle pulse when the bus fails to acknowledge
//   alignErrorOut    : misaligned access presented in IDLE (combinational)
//   memReqOut        : bus request (registered)
//   memWeOut         : bus write enable (registered)
//   memAddrOut       : bus address (registered)
//   memWdataOut      : bus write data (registered)
//   memRdataIn       : bus read data, valid with memAckIn
//   memAckIn         : bus acknowledge, only looked at in ACCESS
// -----------------------------------------------------------------------------
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memReadIn,
  input  logic                  memWriteIn,
  input  logic [ADDR_WIDTH-1:0] addrIn,
  input  logic [DATA_WIDTH-1:0] writeDataIn,
  output logic [DATA_WIDTH-1:0] dataMemoryOut,
  output logic                  stallOut,
  output logic                  busErrorOut,
  output logic                  alignErrorOut,
  output logic                  memReqOut,
  output logic                  memWeOut,
  output logic [ADDR_WIDTH-1:0] memAddrOut,
  output logic [DATA_WIDTH-1:0] memWdataOut,
  input  logic [DATA_WIDTH-1:0] memRdataIn,
  input  logic                  memAckIn
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  memState_t        state;
  logic [CNT_W-1:0] waitCount;

  logic acc;
  logic mis;
  logic issue;
  logic loadOnly;

  assign acc      = memReadIn | memWriteIn;
  assign mis      = (addrIn[1:0] & WORD_ALIGN_MASK) != 2'b00;
  assign issue    = (state == IDLE) && acc && !mis;
  assign loadOnly = memReadIn && !memWriteIn;

  // Both flags are forced low while reset is held so the pipeline is never
  // frozen by whatever stale instruction sits in EX/MEM during reset.
  assign stallOut      = reset && (issue || (state == ACCESS));
  assign alignErrorOut = reset && (state == IDLE) && acc && mis;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent
  // behaviour between this block and any other clocked block.
  // NOTE: reset is asynchronous, so memReqOut and the read buffer clear the
  // instant reset falls, without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      waitCount     <= '0;
      dataMemoryOut <= '0;
      busErrorOut   <= 1'b0;
      memReqOut     <= 1'b0;
      memWeOut      <= 1'b0;
      memAddrOut    <= '0;
      memWdataOut   <= '0;
    end else begin
      busErrorOut <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            memReqOut   <= 1'b1;
            memWeOut    <= memWriteIn;
            memAddrOut  <= addrIn;
            memWdataOut <= writeDataIn;
            waitCount   <= '0;
            state       <= ACCESS;
          end else if (acc && mis && loadOnly) begin
            // A misaligned load must not hand stale data to MEM/WB.
            dataMemoryOut <= '0;
          end
        end

        ACCESS: begin
          // The registered write enable remembers whether this is a load.
          if (memAckIn) begin
            memReqOut <= 1'b0;
            memWeOut  <= 1'b0;
            if (!memWeOut) dataMemoryOut <= memRdataIn;
            state <= HOLD;
          end else if (waitCount == CNT_LAST) begin
            memReqOut   <= 1'b0;
            memWeOut    <= 1'b0;
            busErrorOut <= 1'b1;
            if (!memWeOut) dataMemoryOut <= '0;
            state <= HOLD;
          end else begin
            waitCount <= waitCount + 1'b1;
          end
        end

        // One unstalled cycle lets MEM/WB capture the result; the inputs
        // still show the finished instruction, so nothing is re-issued.
        HOLD: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
